// File: rtl/alu_sequencer.sv
// alu_sequencer: steps one 8085-style ALU instruction through operand fetch, execute and compare restore.
// Optional feature macro ALU_SEQ_CMP_EN: enables CMP/CPI, with saved A reloaded after the compare.
module alu_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] instr,
   input  logic [7:0] imm,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] reg_addr,
   input  logic [7:0] reg_data,
   output logic       mem_req,
   input  logic       mem_ready,
   input  logic [7:0] mem_data,
   input  logic [7:0] a_in,
   input  logic [3:0] flags_in,
   output logic [7:0] bus_out,
   output logic       bus_en,
   output logic       load_a,
   output logic       load_tmp,
   output logic       alu_commit,
   output logic [3:0] op,
   output logic       cin
);

`ifdef ALU_SEQ_CMP_EN
   typedef enum logic [2:0] {IDLE, OPND, MEM, EXEC, RESTORE, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, OPND, MEM, EXEC, DONE} state_t;
`endif

   state_t     state;
   logic [7:0] imm_q;
   logic [7:0] saved_a;
   logic [3:0] op_q;
   logic       carry_q;
   logic       src_imm_q;
`ifdef ALU_SEQ_CMP_EN
   logic       cmp_q;
`endif

   logic       is_rm, is_imm, is_unary, is_cmp, dec_legal, dec_carry;
   logic [3:0] dec_op;

   // Only the carry flag feeds the sequencer; S, Z and P pass straight through the ALU.
   logic unused_flags;
   assign unused_flags = &{1'b0, flags_in[3:1]};

   always_comb begin
      is_rm     = (instr[7:6] == 2'b10);
      is_imm    = (instr[7:6] == 2'b11) && (instr[2:0] == 3'b110);
      is_cmp    = (is_rm || is_imm) && (instr[5:3] == 3'b111);
      dec_carry = (is_rm || is_imm) && ((instr[5:3] == 3'b001) || (instr[5:3] == 3'b011));
      is_unary  = 1'b1;
      dec_op    = 4'b0000;
      case (instr[5:3])
         3'b000, 3'b001: dec_op = 4'b0000;
         3'b100:         dec_op = 4'b0010;
         3'b101:         dec_op = 4'b0100;
         3'b110:         dec_op = 4'b0011;
         default:        dec_op = 4'b0001;
      endcase
      case (instr)
         8'h3C:   dec_op = 4'b0110;
         8'h3D:   dec_op = 4'b0111;
         8'h2F:   dec_op = 4'b0101;
         8'h17:   begin dec_op = 4'b1000; dec_carry = 1'b1; end
         8'h1F:   begin dec_op = 4'b1001; dec_carry = 1'b1; end
         default: is_unary = 1'b0;
      endcase
      dec_legal = is_rm || is_imm || is_unary;
`ifndef ALU_SEQ_CMP_EN
      if (is_cmp) dec_legal = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         imm_q      <= 8'h00;
         saved_a    <= 8'h00;
         op_q       <= 4'b0000;
         carry_q    <= 1'b0;
         src_imm_q  <= 1'b0;
`ifdef ALU_SEQ_CMP_EN
         cmp_q      <= 1'b0;
`endif
         reg_addr   <= 3'b000;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         mem_req    <= 1'b0;
         load_a     <= 1'b0;
         alu_commit <= 1'b0;
         op         <= 4'b0000;
      end else begin
         done       <= 1'b0;
         err        <= 1'b0;
         load_a     <= 1'b0;
         alu_commit <= 1'b0;
         op         <= 4'b0000;
         case (state)
            IDLE: if (start) begin
               imm_q     <= imm;
               saved_a   <= a_in;
               reg_addr  <= instr[2:0];
               op_q      <= dec_op;
               carry_q   <= dec_carry;
               src_imm_q <= is_imm;
`ifdef ALU_SEQ_CMP_EN
               cmp_q     <= is_cmp;
`endif
               busy      <= 1'b1;
               if (!dec_legal) begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else if (is_unary) begin
                  state      <= EXEC;
                  alu_commit <= 1'b1;
                  op         <= dec_op;
               end else if (is_rm && (instr[2:0] == 3'b110)) begin
                  state   <= MEM;
                  mem_req <= 1'b1;
               end else begin
                  state <= OPND;
               end
            end
            OPND: begin
               state      <= EXEC;
               alu_commit <= 1'b1;
               op         <= op_q;
            end
            MEM: if (mem_ready) begin
               mem_req    <= 1'b0;
               state      <= EXEC;
               alu_commit <= 1'b1;
               op         <= op_q;
            end
            EXEC: begin
`ifdef ALU_SEQ_CMP_EN
               if (cmp_q) begin
                  state  <= RESTORE;
                  load_a <= 1'b1;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
`else
               state <= DONE;
               done  <= 1'b1;
`endif
            end
`ifdef ALU_SEQ_CMP_EN
            RESTORE: begin
               state <= DONE;
               done  <= 1'b1;
            end
`endif
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus and load_tmp follow the live operand so a memory word can be taken the cycle it arrives.
   always_comb begin
      bus_out  = 8'h00;
      bus_en   = 1'b0;
      load_tmp = 1'b0;
      cin      = 1'b0;
      case (state)
         OPND: begin
            bus_en   = 1'b1;
            load_tmp = 1'b1;
            bus_out  = src_imm_q ? imm_q : ((reg_addr == 3'b111) ? saved_a : reg_data);
         end
         MEM: if (mem_ready) begin
            bus_en   = 1'b1;
            load_tmp = 1'b1;
            bus_out  = mem_data;
         end
         EXEC: cin = carry_q & flags_in[0];
`ifdef ALU_SEQ_CMP_EN
         RESTORE: begin
            bus_en  = 1'b1;
            bus_out = saved_a;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer against a small ALU/register-file/memory environment and
// checks each instruction against an instruction-level reference (respects ALU_SEQ_CMP_EN).
`timescale 1ns/1ps
module tb_alu_sequencer;
   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [7:0] instr, imm;
   logic       busy, done, err;
   logic [2:0] reg_addr;
   logic [7:0] reg_data;
   logic       mem_req;
   logic       mem_ready = 1'b0;
   logic [7:0] mem_data;
   logic [7:0] a_in;
   logic [3:0] flags_in;
   logic [7:0] bus_out;
   logic       bus_en, load_a, load_tmp, alu_commit;
   logic [3:0] op;
   logic       cin;

   int errors = 0;
   int checks = 0;

   logic [7:0] regs [8];
   logic [7:0] alu_a = 8'h00;
   logic [7:0] alu_tmp = 8'h00;
   logic [3:0] alu_f = 4'h0;
   logic       preset = 1'b0;
   logic [7:0] preset_a = 8'h00;
   logic       preset_c = 1'b0;
   int         mem_wait = 0;
   int         mem_cnt = 0;
   logic [7:0] mem_value = 8'h00;
   logic [7:0] unary_ops [5] = '{8'h3C, 8'h3D, 8'h2F, 8'h17, 8'h1F};

   always #5 clk = ~clk;

   assign reg_data = regs[reg_addr];
   assign a_in     = alu_a;
   assign flags_in = alu_f;
   assign mem_data = mem_ready ? mem_value : 8'hEE;

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .imm(imm),
      .busy(busy), .done(done), .err(err), .reg_addr(reg_addr), .reg_data(reg_data),
      .mem_req(mem_req), .mem_ready(mem_ready), .mem_data(mem_data),
      .a_in(a_in), .flags_in(flags_in), .bus_out(bus_out), .bus_en(bus_en),
      .load_a(load_a), .load_tmp(load_tmp), .alu_commit(alu_commit), .op(op), .cin(cin)
   );

   // Returns {S,Z,P,C, A} for one ALU commit.
   function automatic logic [11:0] aluCalc(input logic [3:0] o, input logic c,
                                           input logic [7:0] a, input logic [7:0] t, input logic fc);
      logic [8:0] r;
      case (o)
         4'b0000: r = {1'b0, a} + {1'b0, t} + {8'b0, c};
         4'b0001: r = {1'b0, a} - {1'b0, t} - {8'b0, c};
         4'b0010: r = {1'b0, a & t};
         4'b0011: r = {1'b0, a | t};
         4'b0100: r = {1'b0, a ^ t};
         4'b0101: r = {1'b0, ~a};
         4'b0110: r = {fc, a + 8'd1};
         4'b0111: r = {fc, a - 8'd1};
         4'b1000: r = {a[7], a[6:0], c};
         4'b1001: r = {a[0], c, a[7:1]};
         default: r = {fc, a};
      endcase
      return {r[7], r[7:0] == 8'h00, ~^r[7:0], r[8], r[7:0]};
   endfunction

   always @(posedge clk) begin
      logic [11:0] res;
      if (preset) begin
         alu_a <= preset_a;
         alu_f <= {3'b000, preset_c};
      end else begin
         if (load_tmp) alu_tmp <= bus_out;
         if (load_a) alu_a <= bus_out;
         if (alu_commit) begin
            res = aluCalc(op, cin, alu_a, alu_tmp, alu_f[0]);
            alu_a <= res[7:0];
            alu_f <= res[11:8];
         end
      end
   end

   // Memory answers after mem_wait cycles of mem_req; mem_ready toggles randomly while not requested.
   always @(posedge clk) begin
      #1;
      if (mem_req) begin
         mem_ready = (mem_cnt == mem_wait);
         mem_cnt++;
      end else begin
         mem_ready = ($urandom_range(0, 1) == 1);
         mem_cnt = 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic presetAlu(input logic [7:0] a, input logic c);
      preset_a = a;
      preset_c = c;
      preset = 1'b1;
      @(negedge clk);
      preset = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] opc, input logic [7:0] immv,
                                input int wait_cycles, input logic [7:0] memv);
      logic [7:0] a0, opnd, exp_a, tmp_seen, loada_seen;
      logic [3:0] exp_op, op_seen;
      logic       c0, exp_cin, cin_seen, err_seen;
      logic       is_rm, is_i, unary, is_cmp, legal, use_mem;
      logic [2:0] grp, sss;
      int         exp_lat, done_cyc, n_tmp, n_commit, n_loada, n_mem, busy_low, excl_bad;

      mem_wait = wait_cycles;
      mem_value = memv;
      a0 = alu_a;
      c0 = alu_f[0];
      grp = opc[5:3];
      sss = opc[2:0];
      is_rm = (opc[7:6] == 2'b10);
      is_i = (opc[7:6] == 2'b11) && (sss == 3'd6);
      unary = (opc == 8'h3C) || (opc == 8'h3D) || (opc == 8'h2F) || (opc == 8'h17) || (opc == 8'h1F);
      is_cmp = (is_rm || is_i) && (grp == 3'd7);
      legal = is_rm || is_i || unary;
`ifndef ALU_SEQ_CMP_EN
      if (is_cmp) legal = 1'b0;
`endif
      use_mem = legal && is_rm && (sss == 3'd6);
      if (is_i) opnd = immv;
      else if (sss == 3'd6) opnd = memv;
      else if (sss == 3'd7) opnd = a0;
      else opnd = regs[sss];

      exp_a = a0;
      exp_op = 4'd0;
      exp_cin = 1'b0;
      if (legal && unary) begin
         case (opc)
            8'h3C:   begin exp_a = a0 + 8'd1; exp_op = 4'd6; end
            8'h3D:   begin exp_a = a0 - 8'd1; exp_op = 4'd7; end
            8'h2F:   begin exp_a = ~a0; exp_op = 4'd5; end
            8'h17:   begin exp_a = {a0[6:0], c0}; exp_op = 4'd8; exp_cin = c0; end
            default: begin exp_a = {c0, a0[7:1]}; exp_op = 4'd9; exp_cin = c0; end
         endcase
      end else if (legal) begin
         case (grp)
            3'd0:    begin exp_a = a0 + opnd; exp_op = 4'd0; end
            3'd1:    begin exp_a = a0 + opnd + {7'b0, c0}; exp_op = 4'd0; exp_cin = c0; end
            3'd2:    begin exp_a = a0 - opnd; exp_op = 4'd1; end
            3'd3:    begin exp_a = a0 - opnd - {7'b0, c0}; exp_op = 4'd1; exp_cin = c0; end
            3'd4:    begin exp_a = a0 & opnd; exp_op = 4'd2; end
            3'd5:    begin exp_a = a0 ^ opnd; exp_op = 4'd4; end
            3'd6:    begin exp_a = a0 | opnd; exp_op = 4'd3; end
            default: begin exp_a = a0; exp_op = 4'd1; end
         endcase
      end
      exp_lat = !legal ? 1 : unary ? 2 : 3 + (use_mem ? wait_cycles : 0) + (is_cmp ? 1 : 0);

      checkOutput("busy_accept", busy, 0);
      start = 1'b1;
      instr = opc;
      imm = immv;
      done_cyc = 0; n_tmp = 0; n_commit = 0; n_loada = 0; n_mem = 0; busy_low = 0; excl_bad = 0;
      tmp_seen = 8'h00; loada_seen = 8'h00; op_seen = 4'h0; cin_seen = 1'b0; err_seen = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         if (load_tmp) begin n_tmp++; tmp_seen = bus_out; end
         if (alu_commit) begin n_commit++; op_seen = op; cin_seen = cin; end
         if (load_a) begin n_loada++; loada_seen = bus_out; end
         if (mem_req) n_mem++;
         if (int'(load_a) + int'(load_tmp) + int'(alu_commit) > 1) excl_bad++;
         if (!busy) busy_low++;
         if (done) begin done_cyc = cyc; err_seen = err; break; end
         start = ($urandom_range(0, 1) == 1);
         instr = 8'($urandom);
         imm = 8'($urandom);
      end
      start = 1'b0;

      if (done_cyc == 0) begin
         checkOutput("done_timeout", done_cyc, exp_lat);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         return;
      end
      checkOutput("latency", done_cyc, exp_lat);
      checkOutput("err", err_seen, !legal);
      checkOutput("n_load_tmp", n_tmp, legal && !unary);
      checkOutput("n_commit", n_commit, legal);
      checkOutput("n_load_a", n_loada, legal && is_cmp);
      checkOutput("n_mem_req", n_mem, use_mem ? wait_cycles + 1 : 0);
      checkOutput("strobe_overlap", excl_bad, 0);
      checkOutput("busy_low", busy_low, 0);
      if (n_tmp == 1) checkOutput("operand", tmp_seen, opnd);
      if (n_commit == 1) begin
         checkOutput("op", op_seen, exp_op);
         checkOutput("cin", cin_seen, exp_cin);
      end
      if (n_loada == 1) checkOutput("restore_bus", loada_seen, a0);
      @(negedge clk);
      checkOutput("busy_after", busy, 0);
      checkOutput("done_after", done, 0);
      checkOutput("result_a", alu_a, exp_a);
      if (legal && is_cmp) checkOutput("cmp_zero", alu_f[2], a0 == opnd);
   endtask

   initial begin
      logic [7:0] opc;
      int         k;
      rst_n = 1'b0; start = 1'b0; instr = 8'h00; imm = 8'h00;
      for (int i = 0; i < 8; i++) regs[i] = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("rst_strobes", {busy, done, err, mem_req, bus_en, load_a, load_tmp, alu_commit, cin}, 0);
      checkOutput("rst_bus_out", bus_out, 0);
      checkOutput("rst_op", op, 0);
      checkOutput("rst_reg_addr", reg_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      regs[0] = 8'h05;
      presetAlu(8'h3C, 1'b0);
      applyStimulus(8'h80, 8'h00, 0, 8'h00);
      checkOutput("add_b_carry", alu_f[0], 0);

      regs[1] = 8'h00;
      presetAlu(8'hFF, 1'b1);
      applyStimulus(8'h89, 8'h00, 0, 8'h00);
      checkOutput("adc_c_zero", alu_f[2], 1);
      checkOutput("adc_c_carry", alu_f[0], 1);

      presetAlu(8'h10, 1'b0);
      applyStimulus(8'h96, 8'h00, 3, 8'h01);

      regs[1] = 8'h10;
      presetAlu(8'h10, 1'b0);
      applyStimulus(8'hB9, 8'h00, 0, 8'h00);

      applyStimulus(8'h00, 8'h00, 0, 8'h00);

      // Reset while the memory operand is still outstanding.
      presetAlu(8'h10, 1'b0);
      mem_wait = 1000;
      start = 1'b1; instr = 8'h96; imm = 8'h00;
      @(negedge clk);
      start = 1'b0;
      checkOutput("mem_req_wait", mem_req, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_mem_req", mem_req, 0);
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_strobes", {done, load_tmp, load_a, alu_commit, bus_en}, 0);
      checkOutput("rst_mid_a", alu_a, 8'h10);
      rst_n = 1'b1;
      mem_wait = 0;
      @(negedge clk);

      for (int n = 0; n < 160; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
            presetAlu(8'($urandom), ($urandom_range(0, 1) == 1));
         end
         k = $urandom_range(0, 9);
         if (k < 5) opc = 8'h80 | 8'($urandom_range(0, 63));
         else if (k < 7) opc = 8'hC6 | (8'($urandom_range(0, 7)) << 3);
         else if (k < 9) opc = unary_ops[$urandom_range(0, 4)];
         else opc = 8'($urandom);
         applyStimulus(opc, 8'($urandom), $urandom_range(0, 4), 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
